// File: rtl/pipeline_issue_ctrl_pkg.sv
// Shared ISA definitions for the issue controller: opcode classes, HALT/NOP
// constants, instruction field positions and controller state encoding.
package pipe_isa_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [5:0]  OP_HALT   = 6'b111111;
    localparam logic [2:0]  CLS_R     = 3'b010;
    localparam logic [2:0]  CLS_I     = 3'b011;

    localparam int REG_W  = 5;
    localparam int OP_LSB = 26;
    localparam int RD_LSB = 21;
    localparam int RS_LSB = 16;
    localparam int RT_LSB = 11;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_HALTED} state_t;
    typedef enum logic [1:0] {K_R, K_I, K_HALT, K_ILL} op_kind_t;

    function automatic op_kind_t op_kind(input logic [5:0] op);
        if (op == OP_HALT)         return K_HALT;
        else if (op[5:3] == CLS_R) return K_R;
        else if (op[5:3] == CLS_I) return K_I;
        else                       return K_ILL;
    endfunction

endpackage

// File: rtl/pipeline_issue_ctrl_if.sv
// Valid/ready instruction source handshake into the issue controller.
interface pipeline_issue_ctrl_if;
    logic [31:0] in_instr;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_instr, output in_valid, input  in_ready);
    modport slave  (input  in_instr, input  in_valid, output in_ready);
endinterface

// File: rtl/pipeline_issue_ctrl_scoreboard.sv
// In-flight destination tracker: a shift register of {valid,rd} compared
// against the candidate instruction's source registers.
module hazard_scoreboard
    import pipe_isa_pkg::*;
#(
    parameter int HAZ_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    input  logic [REG_W-1:0] push_rd,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             chk_rt,
    output logic             hazard
);
    // A producer holds off HAZ_DEPTH-1 following slots (at least one), so only
    // that many registered entries take part in the comparison.
    localparam int WIN = (HAZ_DEPTH > 1) ? HAZ_DEPTH - 1 : 1;

    logic [WIN-1:0]             vld_pipe;
    logic [WIN-1:0][REG_W-1:0]  rd_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            rd_pipe  <= '0;
        end else begin
            vld_pipe[0] <= push_valid;
            rd_pipe[0]  <= push_rd;
            for (int i = 1; i < WIN; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                rd_pipe[i]  <= rd_pipe[i-1];
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            if (vld_pipe[i] && ((rd_pipe[i] == rs) || (chk_rt && (rd_pipe[i] == rt))))
                hazard = 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_issue_ctrl.sv
// Issue controller feeding the 5-stage pipeline: RAW bubbles, illegal drop,
// HALT drain. Optional perf counters enabled by defining PERF_CNT_EN.
module pipeline_issue_ctrl
    import pipe_isa_pkg::*;
#(
    parameter int HAZ_DEPTH  = 3,
    parameter int PIPE_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    pipeline_issue_ctrl_if.slave src,
    output logic [31:0]          instr_out,
    output logic                 issue_valid,
    output logic                 busy,
    output logic                 halted,
    output logic                 err_illegal
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     issue_cnt,
    output logic [CNT_W-1:0]     stall_cnt
`endif
);
    localparam int DRAIN_W = $clog2(PIPE_DEPTH + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH - 1);

    state_t               state_q, state_d;
    op_kind_t             kind;
    logic                 sb_hit, hazard, accept, push_valid;
    logic [31:0]          instr_d;
    logic                 ivld_d, err_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;

    assign kind   = op_kind(src.in_instr[OP_LSB +: 6]);
    assign hazard = src.in_valid && ((kind == K_R) || (kind == K_I)) && sb_hit;
    assign src.in_ready = (state_q == ST_RUN) && !hazard;
    assign accept = src.in_valid && src.in_ready;
    assign busy   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign halted = (state_q == ST_HALTED);

    hazard_scoreboard #(.HAZ_DEPTH(HAZ_DEPTH)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_rd    (src.in_instr[RD_LSB +: REG_W]),
        .rs         (src.in_instr[RS_LSB +: REG_W]),
        .rt         (src.in_instr[RT_LSB +: REG_W]),
        .chk_rt     (kind == K_R),
        .hazard     (sb_hit)
    );

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        instr_d    = NOP_INSTR;
        ivld_d     = 1'b0;
        err_d      = 1'b0;
        push_valid = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (accept) begin
                    case (kind)
                        K_R, K_I: begin
                            instr_d    = src.in_instr;
                            ivld_d     = 1'b1;
                            push_valid = 1'b1;
                        end
                        K_HALT: begin
                            state_d = ST_DRAIN;
                            drain_d = DRAIN_LOAD;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_HALTED;
                else               drain_d = drain_q - 1'b1;
            end
            ST_HALTED: ;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            drain_q     <= '0;
            instr_out   <= NOP_INSTR;
            issue_valid <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            instr_out   <= instr_d;
            issue_valid <= ivld_d;
            err_illegal <= err_d;
        end
    end

`ifdef PERF_CNT_EN
    // Saturating: a wrapped counter would read as a near-idle pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (ivld_d && !(&issue_cnt)) issue_cnt <= issue_cnt + 1'b1;
            if ((state_q == ST_RUN) && hazard && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Self-checking bench: per-register "blocked until edge" model, directed
// scenarios with literal expectations, then randomized instruction streams.
module tb_pipeline_issue_ctrl;
    localparam int HAZ_DEPTH  = 3;
    localparam int PIPE_DEPTH = 4;
    localparam int CNT_W      = 16;
    localparam int WIN        = (HAZ_DEPTH > 1) ? HAZ_DEPTH - 1 : 1;
    localparam longint CMAX   = (longint'(1) << CNT_W) - 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic [31:0] instr_out;
    logic issue_valid, busy, halted, err_illegal;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] issue_cnt, stall_cnt;
`endif

    pipeline_issue_ctrl_if ifc();

    pipeline_issue_ctrl #(.HAZ_DEPTH(HAZ_DEPTH), .PIPE_DEPTH(PIPE_DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src         (ifc),
        .instr_out   (instr_out),
        .issue_valid (issue_valid),
        .busy        (busy),
        .halted      (halted),
        .err_illegal (err_illegal)
`ifdef PERF_CNT_EN
        ,
        .issue_cnt   (issue_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each register remembers the last edge it still blocks.
    int          mstate = M_IDLE;
    int          mcyc = 0;
    int          drain_left = 0;
    int          block_until [32];
    logic [31:0] e_instr = '0;
    logic        e_ivld = 1'b0, e_err = 1'b0;
    longint      m_issue = 0, m_stall = 0;

    function automatic bit m_haz(input logic [31:0] ins, input int n);
        logic [5:0] op;
        bit r_t, i_t;
        op  = ins[31:26];
        r_t = (op[5:3] == 3'b010);
        i_t = (op[5:3] == 3'b011);
        if (!(r_t || i_t)) return 1'b0;
        return (block_until[ins[20:16]] >= n) || (r_t && (block_until[ins[15:11]] >= n));
    endfunction

    initial begin
        foreach (block_until[i]) block_until[i] = -1;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mstate = M_IDLE; drain_left = 0;
                e_instr = '0; e_ivld = 1'b0; e_err = 1'b0;
                m_issue = 0; m_stall = 0;
                foreach (block_until[i]) block_until[i] = -1;
            end else begin
                bit haz;
                logic [5:0] op;
                mcyc++;
                haz = ifc.in_valid && m_haz(ifc.in_instr, mcyc);
                op  = ifc.in_instr[31:26];
                e_instr = '0; e_ivld = 1'b0; e_err = 1'b0;
                case (mstate)
                    M_IDLE: if (start) mstate = M_RUN;
                    M_RUN: begin
                        if (haz && m_stall < CMAX) m_stall++;
                        if (ifc.in_valid && !haz) begin
                            if (op == 6'b111111) begin
                                mstate = M_DRAIN; drain_left = PIPE_DEPTH;
                            end else if (op[5:4] == 2'b01) begin
                                e_instr = ifc.in_instr; e_ivld = 1'b1;
                                block_until[ifc.in_instr[25:21]] = mcyc + WIN;
                                if (m_issue < CMAX) m_issue++;
                            end else e_err = 1'b1;
                        end
                    end
                    M_DRAIN: begin
                        drain_left--;
                        if (drain_left == 0) mstate = M_HALTED;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial forever begin
        bit exp_ready;
        @(negedge clk);
        exp_ready = (mstate == M_RUN) && !(ifc.in_valid && m_haz(ifc.in_instr, mcyc + 1));
        chk("instr_out",   instr_out,    e_instr);
        chk("issue_valid", issue_valid,  e_ivld);
        chk("err_illegal", err_illegal,  e_err);
        chk("busy",        busy,         (mstate == M_RUN) || (mstate == M_DRAIN));
        chk("halted",      halted,       mstate == M_HALTED);
        chk("in_ready",    ifc.in_ready, exp_ready);
`ifdef PERF_CNT_EN
        chk("issue_cnt",   issue_cnt,    m_issue[CNT_W-1:0]);
        chk("stall_cnt",   stall_cnt,    m_stall[CNT_W-1:0]);
`endif
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one instruction and hold it until accepted; t = edges taken.
    task automatic send(input logic [31:0] ins, output int t);
        logic acc;
        t = 0;
        ifc.in_instr = ins;
        ifc.in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = ifc.in_ready;
            @(posedge clk); #1;
            t++;
        end while (!acc && t < 40);
        ifc.in_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: instr %08h not accepted after %0d cycles", ins, t);
        end
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [5:0] op;
        int k;
        k = $urandom_range(0, 9);
        if (k < 4)      op = {3'b010, 3'($urandom_range(0, 7))};
        else if (k < 8) op = {3'b011, 3'($urandom_range(0, 7))};
        else            op = 6'($urandom_range(0, 15));
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 11'($urandom)};
    endfunction

    initial begin
        int t;
        ifc.in_instr = '0;
        ifc.in_valid = 1'b0;

        // 1. reset, then start
        #1 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_in_ready",  ifc.in_ready, 1'b0);
        chk("rst_halted",    halted, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);
        pulse_start();
        @(negedge clk);
        chk("start_busy",     busy, 1'b1);
        chk("start_in_ready", ifc.in_ready, 1'b1);
        @(posedge clk); #1;

        // 2. independent back-to-back
        send(32'h7421000A, t); chk("addi_latency", t, 1);
        send(32'h6C420002, t); chk("ori_no_bubble", t, 1);

        // 3. RAW stall: ADD r3 = r1 + r2 after ORI r2
        idle(3);
        send(32'h6C420002, t); chk("ori2_latency", t, 1);
        send(32'h54611000, t); chk("raw_edges", t, 3);
`ifdef PERF_CNT_EN
        @(negedge clk);
        chk("raw_stall_cnt", stall_cnt, 16'd2);
        @(posedge clk); #1;
`endif

        // 4. illegal opcode
        idle(2);
        send(32'h00000000, t);
        @(negedge clk);
        chk("ill_err",   err_illegal, 1'b1);
        chk("ill_ivld",  issue_valid, 1'b0);
        chk("ill_instr", instr_out, 32'h0);
        @(negedge clk);
        chk("ill_err_1cyc", err_illegal, 1'b0);
        @(posedge clk); #1;

        // 6. reset while ADD is stalled behind ORI
        idle(3);
        send(32'h6C420002, t);
        ifc.in_instr = 32'h54611000;
        ifc.in_valid = 1'b1;
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ivld",  issue_valid, 1'b0);
        chk("rst_mid_instr", instr_out, 32'h0);
        chk("rst_mid_busy",  busy, 1'b0);
        ifc.in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        pulse_start();
        send(32'h54611000, t); chk("post_rst_no_stall", t, 1);

        // randomized stream against the model
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(rnd_instr(), t);
        end

        // 5. HALT drain with the source still offering work
        idle(2);
        send(32'hFFFFFFFF, t);
        ifc.in_instr = 32'h7421000A;
        ifc.in_valid = 1'b1;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            @(negedge clk);
            chk("drain_busy",  busy, 1'b1);
            chk("drain_ready", ifc.in_ready, 1'b0);
            chk("drain_nop",   instr_out, 32'h0);
        end
        @(negedge clk);
        chk("halted_set",   halted, 1'b1);
        chk("halted_ready", ifc.in_ready, 1'b0);
        pulse_start();
        idle(3);
        @(negedge clk);
        chk("halted_sticky", halted, 1'b1);
        ifc.in_valid = 1'b0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
